// File: rtl/control_unit_pkg.sv
// RV32I control decode shared definitions.
// Opcodes, select encodings and the ctrl_bundle output record.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] CMP_BEQ  = 5'd10;
  localparam logic [4:0] CMP_BLT  = 5'd12;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic A_RS1 = 1'b0;
  localparam logic A_PC  = 1'b1;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_UIMM = 2'b10;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_RS2  = 2'b01;
  localparam logic [1:0] SH_IMM  = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;

  typedef struct packed {
    logic [1:0] size_sel;
    logic [4:0] op;
    logic       mem_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [1:0] b_sel;
    logic       a_sel;
    logic [1:0] wb_sel;
    logic [1:0] sh_sel;
    logic       reg_we;
    logic [1:0] ext_sel;
  } ctrl_bundle;

  localparam ctrl_bundle CTRL_DEFAULT = '0;

  // alt selects SUB/SRA; caller decides when it applies.
  function automatic logic [4:0] alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [4:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000: r = alt ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-field in / control-select out bundle.
// master: fetch side drives fields; slave: control unit drives selects.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [1:0] size_sel;
  logic [4:0] operation_sel;
  logic       enable_write;
  logic [1:0] PC_genrator_sel;
  logic [2:0] imm_sel;
  logic [1:0] rs2_or_imm_or_4;
  logic       PC_or_rs1;
  logic [1:0] ALU_or_load_or_immShiftedBy12;
  logic [1:0] Shift_amount;
  logic       Enable_Reg;
  logic [1:0] sign_selection;

  modport master (
    output opcode, func3, func7,
    input  size_sel, operation_sel, enable_write,
    input  PC_genrator_sel, imm_sel, rs2_or_imm_or_4,
    input  PC_or_rs1, ALU_or_load_or_immShiftedBy12,
    input  Shift_amount, Enable_Reg, sign_selection
  );

  modport slave (
    input  opcode, func3, func7,
    output size_sel, operation_sel, enable_write,
    output PC_genrator_sel, imm_sel, rs2_or_imm_or_4,
    output PC_or_rs1, ALU_or_load_or_immShiftedBy12,
    output Shift_amount, Enable_Reg, sign_selection
  );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational RV32I decode: opcode/func3/func7 -> ctrl_bundle.
// Illegal encodings yield CTRL_DEFAULT (no writes, PC+4).
module control_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_bundle ctrl
);

  logic is_shift;
  logic alt;
  logic base;

  assign is_shift = (func3 == 3'b001) || (func3 == 3'b101);
  assign alt      = (func7 == F7_ALT);
  assign base     = (func7 == F7_BASE);

  always_comb begin
    ctrl = CTRL_DEFAULT;
    unique case (1'b1)
      opcode == OP_R: begin
        if (base || (alt && (func3 == 3'b000 ||
                             func3 == 3'b101))) begin
          ctrl.op     = alu_op(func3, alt);
          ctrl.reg_we = 1'b1;
          ctrl.sh_sel = is_shift ? SH_RS2 : SH_NONE;
        end
      end
      opcode == OP_I: begin
        // func7 is immediate data except on shifts.
        if (!is_shift || base ||
            (alt && func3 == 3'b101)) begin
          ctrl.op      = alu_op(func3,
                                alt && func3 == 3'b101);
          ctrl.b_sel   = B_IMM;
          ctrl.imm_sel = IMM_I;
          ctrl.reg_we  = 1'b1;
          ctrl.sh_sel  = is_shift ? SH_IMM : SH_NONE;
        end
      end
      opcode == OP_LOAD: begin
        if (func3[1:0] != 2'b11 && func3 != 3'b110) begin
          ctrl.b_sel    = B_IMM;
          ctrl.wb_sel   = WB_LOAD;
          ctrl.reg_we   = 1'b1;
          ctrl.size_sel = func3[1:0];
          ctrl.ext_sel  = func3[2] ? EXT_ZERO : EXT_SIGN;
        end
      end
      opcode == OP_STORE: begin
        if (!func3[2] && func3[1:0] != 2'b11) begin
          ctrl.b_sel    = B_IMM;
          ctrl.imm_sel  = IMM_S;
          ctrl.mem_we   = 1'b1;
          ctrl.size_sel = func3[1:0];
        end
      end
      opcode == OP_BRANCH: begin
        // 010/011 are holes in the branch func3 space.
        if (func3[2:1] != 2'b01) begin
          ctrl.op = func3[2]
                  ? CMP_BLT + {3'b000, func3[1:0]}
                  : CMP_BEQ + {4'b0000, func3[0]};
          ctrl.imm_sel = IMM_B;
          ctrl.pc_sel  = PC_BRANCH;
        end
      end
      opcode == OP_JAL: begin
        ctrl.a_sel   = A_PC;
        ctrl.b_sel   = B_FOUR;
        ctrl.imm_sel = IMM_J;
        ctrl.pc_sel  = PC_JAL;
        ctrl.reg_we  = 1'b1;
      end
      opcode == OP_JALR: begin
        if (func3 == 3'b000) begin
          ctrl.a_sel   = A_PC;
          ctrl.b_sel   = B_FOUR;
          ctrl.imm_sel = IMM_I;
          ctrl.pc_sel  = PC_JALR;
          ctrl.reg_we  = 1'b1;
        end
      end
      opcode == OP_LUI: begin
        ctrl.imm_sel = IMM_U;
        ctrl.wb_sel  = WB_UIMM;
        ctrl.reg_we  = 1'b1;
      end
      opcode == OP_AUIPC: begin
        ctrl.a_sel   = A_PC;
        ctrl.b_sel   = B_IMM;
        ctrl.imm_sel = IMM_U;
        ctrl.reg_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder with registered outputs (1-cycle latency).
// clk, rst_n (async low) and a control_unit_if slave port.
module control_unit
  import rv32_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  bus
);

  ctrl_bundle nxt;
  ctrl_bundle q;

  control_decode u_dec (
    .opcode (bus.opcode),
    .func3  (bus.func3),
    .func7  (bus.func7),
    .ctrl   (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= CTRL_DEFAULT;
    else        q <= nxt;
  end

  assign bus.size_sel        = q.size_sel;
  assign bus.operation_sel   = q.op;
  assign bus.enable_write    = q.mem_we;
  assign bus.PC_genrator_sel = q.pc_sel;
  assign bus.imm_sel         = q.imm_sel;
  assign bus.rs2_or_imm_or_4 = q.b_sel;
  assign bus.PC_or_rs1       = q.a_sel;
  assign bus.ALU_or_load_or_immShiftedBy12 = q.wb_sel;
  assign bus.Shift_amount    = q.sh_sel;
  assign bus.Enable_Reg      = q.reg_we;
  assign bus.sign_selection  = q.ext_sel;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: vector table, corner sequences,
// and random instructions against a mnemonic-level model.
module tb_control_unit;

  typedef struct packed {
    logic [1:0] size;
    logic [4:0] op;
    logic       we;
    logic [1:0] pc;
    logic [2:0] imm;
    logic [1:0] b;
    logic       a;
    logic [1:0] wb;
    logic [1:0] sh;
    logic       rg;
    logic [1:0] sgn;
  } exp_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t got();
    return {bus.size_sel, bus.operation_sel,
            bus.enable_write, bus.PC_genrator_sel,
            bus.imm_sel, bus.rs2_or_imm_or_4,
            bus.PC_or_rs1,
            bus.ALU_or_load_or_immShiftedBy12,
            bus.Shift_amount, bus.Enable_Reg,
            bus.sign_selection};
  endfunction

  function automatic exp_t mk(
    int size, int op, int we, int pc, int imm,
    int b, int a, int wb, int sh, int rg, int sgn
  );
    exp_t e;
    e.size = 2'(size); e.op  = 5'(op);
    e.we   = 1'(we);   e.pc  = 2'(pc);
    e.imm  = 3'(imm);  e.b   = 2'(b);
    e.a    = 1'(a);    e.wb  = 2'(wb);
    e.sh   = 2'(sh);   e.rg  = 1'(rg);
    e.sgn  = 2'(sgn);
    return e;
  endfunction

  // Reference: classify the instruction, then fill fields.
  function automatic exp_t model(
    logic [6:0] op, logic [2:0] f3, logic [6:0] f7
  );
    exp_t e = '0;
    int rops[8];
    int br[6];
    bit alt  = (f7 == 7'h20);
    bit base = (f7 == 7'h00);
    bit shf  = (f3 == 3'd1) || (f3 == 3'd5);
    int k    = int'(f3);
    rops = '{0, 2, 3, 4, 5, 6, 8, 9};
    br   = '{0, 1, 4, 5, 6, 7};
    case (op)
      7'h33: if (base || (alt && (k == 0 || k == 5))) begin
        e.op = 5'(rops[k] + (alt ? 1 : 0));
        e.rg = 1; e.sh = shf ? 2'd1 : 2'd0;
      end
      7'h13: if (!shf || base || (alt && k == 5)) begin
        e.op = 5'(rops[k] + ((alt && k == 5) ? 1 : 0));
        e.rg = 1; e.b = 1; e.sh = shf ? 2'd2 : 2'd0;
      end
      7'h03: if (k inside {0, 1, 2, 4, 5}) begin
        e.b = 1; e.wb = 1; e.rg = 1;
        e.size = 2'(k % 4); e.sgn = (k >= 4) ? 2'd1 : 2'd0;
      end
      7'h23: if (k < 3) begin
        e.b = 1; e.imm = 1; e.we = 1; e.size = 2'(k);
      end
      7'h63: for (int i = 0; i < 6; i++)
        if (br[i] == k) begin
          e.op = 5'(10 + i); e.imm = 2; e.pc = 1;
        end
      7'h6f: begin
        e.a = 1; e.b = 2; e.imm = 4; e.pc = 2; e.rg = 1;
      end
      7'h67: if (k == 0) begin
        e.a = 1; e.b = 2; e.pc = 3; e.rg = 1;
      end
      7'h37: begin e.imm = 3; e.wb = 2; e.rg = 1; end
      7'h17: begin e.a = 1; e.b = 1; e.imm = 3; e.rg = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t g = got();
    n_cmp++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask

  task automatic drive(
    logic [6:0] op, logic [2:0] f3, logic [6:0] f7
  );
    bus.opcode = op;
    bus.func3  = f3;
    bus.func7  = f7;
  endtask

  vec_t tbl[20];
  logic [6:0] ops[9];
  logic [6:0] rop, rf7;
  logic [2:0] rf3;
  exp_t prev;

  initial begin
    // size op we pc imm b a wb sh rg sgn
    tbl[0]  = '{"add",  7'h33, 3'd0, 7'h00,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[1]  = '{"sub",  7'h33, 3'd0, 7'h20,
                mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{"sra",  7'h33, 3'd5, 7'h20,
                mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0)};
    tbl[3]  = '{"sltu", 7'h33, 3'd3, 7'h00,
                mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{"r_bad_f7", 7'h33, 3'd0, 7'h01,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{"srai", 7'h13, 3'd5, 7'h20,
                mk(0, 7, 0, 0, 0, 1, 0, 0, 2, 1, 0)};
    tbl[6]  = '{"addi_nosub", 7'h13, 3'd0, 7'h20,
                mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)};
    tbl[7]  = '{"lhu",  7'h03, 3'd5, 7'h00,
                mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1)};
    tbl[8]  = '{"lb",   7'h03, 3'd0, 7'h00,
                mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0)};
    tbl[9]  = '{"sw",   7'h23, 3'd2, 7'h00,
                mk(2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[10] = '{"bgeu", 7'h63, 3'd7, 7'h00,
                mk(0, 15, 0, 1, 2, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{"beq",  7'h63, 3'd0, 7'h00,
                mk(0, 10, 0, 1, 2, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{"bne",  7'h63, 3'd1, 7'h00,
                mk(0, 11, 0, 1, 2, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{"blt",  7'h63, 3'd4, 7'h00,
                mk(0, 12, 0, 1, 2, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{"br_010", 7'h63, 3'd2, 7'h00,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{"jal",  7'h6f, 3'd3, 7'h11,
                mk(0, 0, 0, 2, 4, 2, 1, 0, 0, 1, 0)};
    tbl[16] = '{"jalr", 7'h67, 3'd0, 7'h00,
                mk(0, 0, 0, 3, 0, 2, 1, 0, 0, 1, 0)};
    tbl[17] = '{"lui",  7'h37, 3'd6, 7'h7f,
                mk(0, 0, 0, 0, 3, 0, 0, 2, 0, 1, 0)};
    tbl[18] = '{"auipc", 7'h17, 3'd1, 7'h05,
                mk(0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0)};
    tbl[19] = '{"illegal", 7'h7f, 3'd0, 7'h00,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h6f, 7'h67, 7'h37, 7'h17};

    // Async reset with R-type on the inputs.
    drive(7'h33, 3'd0, 7'h00);
    #1 rst_n = 1'b0;
    #1 check("reset_async", '0);
    @(posedge clk); #1 check("reset_held", '0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("reset_release_pre", '0);
    @(posedge clk); #1;
    check("reset_release", model(7'h33, 3'd0, 7'h00));

    // Table vectors.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7);
      @(posedge clk); #1;
      check(tbl[i].name, tbl[i].e);
    end

    // Latency: new inputs invisible until the next edge.
    @(negedge clk);
    drive(7'h6f, 3'd0, 7'h00);
    @(posedge clk); #1;
    prev = got();
    @(negedge clk);
    drive(7'h23, 3'd0, 7'h00);
    #1 check("latency_hold", tbl[15].e);
    @(posedge clk); #1;
    check("latency_edge",
          mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));

    // Mid-stream reset drops bundle; first edge after
    // release reflects the current inputs.
    @(negedge clk);
    drive(7'h37, 3'd0, 7'h00);
    #2 rst_n = 1'b0;
    #1 check("midreset_clear", '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_resume", tbl[17].e);

    // Random instructions against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rop = ($urandom_range(0, 9) == 9)
          ? 7'($urandom) : ops[$urandom_range(0, 8)];
      rf3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        default: rf7 = 7'($urandom);
      endcase
      drive(rop, rf3, rf7);
      @(posedge clk); #1;
      check($sformatf("rand op=%h f3=%0d f7=%h",
                      rop, rf3, rf7),
            model(rop, rf3, rf7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
